// File: rtl/onehot_encoder_pipe_pkg.sv
// enc_pkg: shared encoder mode encodings and width helper.
// Used by onehot_encoder_core and onehot_encoder_pipe. No ports.
package enc_pkg;

  typedef enum int {
    MODE_STRICT = 0,
    MODE_LSB    = 1,
    MODE_MSB    = 2
  } enc_mode_e;

  // Index width for an n-bit vector.
  // A width of 0 is never returned, so the result is always a legal port width.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_encoder_core.sv
// onehot_encoder_core: purely combinational N-to-IW encoder.
// Ports:
//   vec_i  [N-1:0]  vector to encode
//   idx_o  [IW-1:0] encoded index (0 for zero/illegal vectors)
//   zero_o          vector has no bits set
//   err_o           strict mode only: vector is not exactly one-hot
module onehot_encoder_core
  import enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_STRICT,
  parameter int IW   = clog2_min1(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          zero_o,
  output logic          err_o
);

  localparam int unsigned NU = N;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [IW-1:0] lsb_idx;
  logic [IW-1:0] msb_idx;
  logic          multi;

  // Ascending scan: the last hit is the highest set bit.
  // Descending scan: the last hit is the lowest set bit.
  always_comb begin
    lsb_idx = '0;
    msb_idx = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (vec_i[i]) msb_idx = IW'(i);
    end
    for (int unsigned i = NU; i > 0; i--) begin
      if (vec_i[i-1]) lsb_idx = IW'(i - 1);
    end
  end

  assign zero_o = (vec_i == '0);
  // Clearing the lowest set bit leaves a nonzero value iff more than one bit was set.
  assign multi  = ((vec_i & (vec_i - ONE)) != '0);

  always_comb begin
    idx_o = '0;
    err_o = 1'b0;
    if (MODE == MODE_LSB) begin
      idx_o = lsb_idx;
    end else if (MODE == MODE_MSB) begin
      idx_o = msb_idx;
    end else begin
      err_o = zero_o | multi;
      idx_o = (zero_o | multi) ? '0 : lsb_idx;
    end
  end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: registered N-to-log2(N) encoder with valid/ready on both
// sides and a saturating error counter.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_vec [N-1:0] vector to encode
//   out_valid/out_ready   output handshake
//   out_idx [IW-1:0]      encoded index
//   out_zero, out_err     zero-vector flag, strict-mode illegal flag
//   err_cnt [ECW-1:0]     saturating count of accepted vectors with err set
//   err_clr               synchronous clear of err_cnt (wins over increment)
module onehot_encoder_pipe
  import enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int IW   = clog2_min1(N),
  parameter int MODE = MODE_STRICT,
  parameter int ECW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_vec,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IW-1:0]  out_idx,
  output logic           out_zero,
  output logic           out_err,
  output logic [ECW-1:0] err_cnt,
  input  logic           err_clr
);

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $fatal(1, "onehot_encoder_pipe: MODE must be 0, 1 or 2");
  end
  if (N < 2 || N > 256) begin : g_bad_n
    $fatal(1, "onehot_encoder_pipe: N must be in 2..256");
  end

  logic [IW-1:0]  core_idx;
  logic           core_zero;
  logic           core_err;
  logic           accept;

  logic           valid_q, valid_d;
  logic [IW-1:0]  idx_q,   idx_d;
  logic           zero_q,  zero_d;
  logic           err_q,   err_d;
  logic [ECW-1:0] cnt_q,   cnt_d;

  onehot_encoder_core #(
    .N    (N),
    .MODE (MODE),
    .IW   (IW)
  ) u_core (
    .vec_i  (in_vec),
    .idx_o  (core_idx),
    .zero_o (core_zero),
    .err_o  (core_err)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    zero_d  = zero_q;
    err_d   = err_q;
    if (accept) begin
      valid_d = 1'b1;
      idx_d   = core_idx;
      zero_d  = core_zero;
      err_d   = core_err;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (accept && core_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + ECW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_zero  = zero_q;
  assign out_err   = err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Directed bench for onehot_encoder_pipe: strict N=8, LSB/MSB N=16, strict ECW=2.
module tb_onehot_encoder_pipe;
  import enc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // A: strict, N=8, ECW=8
  logic       a_valid = 0, a_out_ready = 0, a_clr = 0;
  logic [7:0] a_vec = '0;
  logic       a_in_ready, a_out_valid, a_zero, a_err;
  logic [2:0] a_idx;
  logic [7:0] a_cnt;

  // B/C: LSB and MSB priority, N=16, shared stimulus
  logic        b_valid = 0, b_out_ready = 1, b_clr = 0;
  logic [15:0] b_vec = '0;
  logic        b_in_ready, b_out_valid, b_zero, b_err;
  logic        c_in_ready, c_out_valid, c_zero, c_err;
  logic [3:0]  b_idx, c_idx;
  logic [7:0]  b_cnt, c_cnt;

  // D: strict, N=8, ECW=2
  logic       d_valid = 0, d_out_ready = 0, d_clr = 0;
  logic [7:0] d_vec = '0;
  logic       d_in_ready, d_out_valid, d_zero, d_err;
  logic [2:0] d_idx;
  logic [1:0] d_cnt;

  onehot_encoder_pipe #(.N(8), .MODE(MODE_STRICT), .ECW(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_in_ready), .in_vec(a_vec),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_idx),
    .out_zero(a_zero), .out_err(a_err), .err_cnt(a_cnt), .err_clr(a_clr));

  onehot_encoder_pipe #(.N(16), .MODE(MODE_LSB), .ECW(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_in_ready), .in_vec(b_vec),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_idx),
    .out_zero(b_zero), .out_err(b_err), .err_cnt(b_cnt), .err_clr(b_clr));

  onehot_encoder_pipe #(.N(16), .MODE(MODE_MSB), .ECW(8)) u_c (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(c_in_ready), .in_vec(b_vec),
    .out_valid(c_out_valid), .out_ready(b_out_ready), .out_idx(c_idx),
    .out_zero(c_zero), .out_err(c_err), .err_cnt(c_cnt), .err_clr(b_clr));

  onehot_encoder_pipe #(.N(8), .MODE(MODE_STRICT), .ECW(2)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_valid), .in_ready(d_in_ready), .in_vec(d_vec),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_idx(d_idx),
    .out_zero(d_zero), .out_err(d_err), .err_cnt(d_cnt), .err_clr(d_clr));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed views {valid, idx, zero, err}
  function automatic logic [5:0] a_view();
    return {a_out_valid, a_idx, a_zero, a_err};
  endfunction
  function automatic logic [6:0] b_view();
    return {b_out_valid, b_idx, b_zero, b_err};
  endfunction
  function automatic logic [6:0] c_view();
    return {c_out_valid, c_idx, c_zero, c_err};
  endfunction

  task automatic test_reset();
    #3;
    n_vec++;
    if (a_view() !== 6'b0) begin
      n_err++; $display("FAIL reset_out got=%b exp=%b", a_view(), 6'b0);
    end
    n_vec++;
    if (a_cnt !== 8'd0 || d_cnt !== 2'd0) begin
      n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", a_cnt, d_cnt);
    end
    n_vec++;
    if (a_in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_valid got=%b exp=0", a_out_valid);
    end
  endtask

  task automatic test_strict_walk();
    logic [5:0] exp;
    a_out_ready = 1'b1;
    a_valid     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_vec = 8'b1 << i;
      n_vec++;
      if (a_in_ready !== 1'b1) begin
        n_err++; $display("FAIL walk_in_ready[%0d] got=%b exp=1", i, a_in_ready);
      end
      step();
      exp = {1'b1, 3'(i), 1'b0, 1'b0};
      n_vec++;
      if (a_view() !== exp) begin
        n_err++; $display("FAIL walk_out[%0d] got=%b exp=%b", i, a_view(), exp);
      end
    end
    a_valid = 1'b0;
    n_vec++;
    if (a_cnt !== 8'd0) begin
      n_err++; $display("FAIL walk_cnt got=%0d exp=0", a_cnt);
    end
    step();
    n_vec++;
    if (a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL walk_drain got=%b exp=0", a_out_valid);
    end
  endtask

  task automatic test_strict_illegal();
    a_valid = 1'b1;
    a_vec   = 8'b0001_0100;
    step();
    n_vec++;
    if (a_view() !== 6'b1_000_0_1) begin
      n_err++; $display("FAIL illegal_multi got=%b exp=%b", a_view(), 6'b1_000_0_1);
    end
    a_vec = 8'h00;
    step();
    n_vec++;
    if (a_view() !== 6'b1_000_1_1) begin
      n_err++; $display("FAIL illegal_zero got=%b exp=%b", a_view(), 6'b1_000_1_1);
    end
    n_vec++;
    if (a_cnt !== 8'd2) begin
      n_err++; $display("FAIL illegal_cnt got=%0d exp=2", a_cnt);
    end
    a_valid = 1'b0;
    step();
  endtask

  task automatic test_priority();
    b_valid = 1'b1;
    b_vec   = 16'h0A50;
    step();
    n_vec++;
    if (b_view() !== {1'b1, 4'd4, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL lsb_0a50 got=%b exp=%b", b_view(), {1'b1, 4'd4, 2'b00});
    end
    n_vec++;
    if (c_view() !== {1'b1, 4'd11, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL msb_0a50 got=%b exp=%b", c_view(), {1'b1, 4'd11, 2'b00});
    end
    b_vec = 16'h0000;
    step();
    n_vec++;
    if (b_view() !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL lsb_zero got=%b exp=%b", b_view(), {1'b1, 4'd0, 2'b10});
    end
    n_vec++;
    if (c_view() !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL msb_zero got=%b exp=%b", c_view(), {1'b1, 4'd0, 2'b10});
    end
    b_vec = 16'h8001;
    step();
    n_vec++;
    if (b_idx !== 4'd0 || c_idx !== 4'd15) begin
      n_err++; $display("FAIL prio_8001 got=%0d/%0d exp=0/15", b_idx, c_idx);
    end
    n_vec++;
    if (b_cnt !== 8'd0 || c_cnt !== 8'd0) begin
      n_err++; $display("FAIL prio_cnt got=%0d/%0d exp=0/0", b_cnt, c_cnt);
    end
    b_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_valid     = 1'b1;
    a_vec       = 8'h08;
    step();
    n_vec++;
    if (a_view() !== 6'b1_011_0_0) begin
      n_err++; $display("FAIL bp_first got=%b exp=%b", a_view(), 6'b1_011_0_0);
    end
    a_vec = 8'h40;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (a_in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, a_in_ready);
      end
      step();
      n_vec++;
      if (a_view() !== 6'b1_011_0_0) begin
        n_err++; $display("FAIL bp_hold[%0d] got=%b exp=%b", k, a_view(), 6'b1_011_0_0);
      end
    end
    a_out_ready = 1'b1;
    #1;
    n_vec++;
    if (a_in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release_ready got=%b exp=1", a_in_ready);
    end
    step();
    n_vec++;
    if (a_view() !== 6'b1_110_0_0) begin
      n_err++; $display("FAIL bp_no_bubble got=%b exp=%b", a_view(), 6'b1_110_0_0);
    end
    a_valid = 1'b0;
    step();
    n_vec++;
    if (a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drain got=%b exp=0", a_out_valid);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] ill [6];
    logic [1:0] exp;
    ill = '{8'h03, 8'h00, 8'hFF, 8'h05, 8'h00, 8'h81};
    d_out_ready = 1'b1;
    d_valid     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d_vec = ill[k];
      step();
      exp = (k >= 2) ? 2'd3 : 2'(k + 1);
      n_vec++;
      if (d_cnt !== exp || d_err !== 1'b1) begin
        n_err++; $display("FAIL sat_cnt[%0d] got=%0d err=%b exp=%0d err=1", k, d_cnt, d_err, exp);
      end
    end
    d_vec = 8'h06;
    d_clr = 1'b1;
    step();
    n_vec++;
    if (d_cnt !== 2'd0 || d_err !== 1'b1) begin
      n_err++; $display("FAIL sat_clr got=%0d err=%b exp=0 err=1", d_cnt, d_err);
    end
    d_clr   = 1'b0;
    d_valid = 1'b0;
    step();
    n_vec++;
    if (d_cnt !== 2'd0) begin
      n_err++; $display("FAIL sat_after_clr got=%0d exp=0", d_cnt);
    end
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0;
    a_valid     = 1'b1;
    a_vec       = 8'h00;
    step();
    a_valid = 1'b0;
    n_vec++;
    if (a_view() !== 6'b1_000_1_1 || a_cnt !== 8'd3) begin
      n_err++; $display("FAIL pre_rst got=%b cnt=%0d exp=%b cnt=3", a_view(), a_cnt, 6'b1_000_1_1);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (a_view() !== 6'b0 || a_cnt !== 8'd0) begin
      n_err++; $display("FAIL async_rst got=%b cnt=%0d exp=%b cnt=0", a_view(), a_cnt, 6'b0);
    end
    n_vec++;
    if (a_in_ready !== 1'b1) begin
      n_err++; $display("FAIL async_rst_ready got=%b exp=1", a_in_ready);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL post_async_rst got=%b exp=0", a_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_strict_walk();
    test_strict_illegal();
    test_priority();
    test_backpressure();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
